// File: rtl/ep_core_param.sv
// Parametrised accumulator processor: program RAM, accumulator datapath and a
// FETCH/DECODE/EXECUTE controller with an Enter-handshaked INPUT and a HALT state.
module ep_core_param #(
    parameter  int DATA_W = 8,
    localparam int ADDR_W = DATA_W - 3
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Input,
    input  logic              Enter,
    input  logic              ProgWr,
    input  logic [ADDR_W-1:0] ProgAddr,
    input  logic [DATA_W-1:0] ProgData,
    output logic [DATA_W-1:0] Output,
    output logic              Halt,
    output logic              Aeq0,
    output logic              Apos,
    output logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] IR,
    output logic [2:0]        State
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_START   = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_HALT    = 3'd7
    } state_t;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_INPUT = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   pc_r;
    logic [DATA_W-1:0]   ir_r;
    logic [DATA_W-1:0]   a_r;
    logic                halt_r;
    logic [DATA_W-1:0]   mem_r [0:DEPTH-1];

    logic [2:0]          opcode_s;
    logic [ADDR_W-1:0]   ir_addr_s;
    logic [ADDR_W-1:0]   mem_addr_s;
    logic [DATA_W-1:0]   mem_rdata_s;
    logic                aeq0_s;
    logic                apos_s;
    logic                store_en_s;
    logic                prog_en_s;

    assign opcode_s    = ir_r[DATA_W-1 -: 3];
    assign ir_addr_s   = ir_r[ADDR_W-1:0];
    assign mem_rdata_s = mem_r[mem_addr_s];
    assign aeq0_s      = (a_r == {DATA_W{1'b0}});
    assign apos_s      = !aeq0_s && !a_r[DATA_W-1];

    // Reset suppresses STORE, and program loading is only open while the core is
    // parked (in reset or halted), so the two write ports can never collide.
    assign store_en_s = !Reset && (state_r == ST_EXECUTE) && (opcode_s == OP_STORE);
    assign prog_en_s  = ProgWr && (Reset || (state_r == ST_HALT));

    // RAM address: the program counter while fetching, the operand field otherwise.
    always_comb begin
        mem_addr_s = ir_addr_s;
        if (state_r == ST_FETCH) begin
            mem_addr_s = pc_r;
        end else begin
            mem_addr_s = ir_addr_s;
        end
    end

    // Controller next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_START:   state_s = ST_FETCH;
            ST_FETCH:   state_s = ST_DECODE;
            ST_DECODE: begin
                if (opcode_s == OP_HALT) begin
                    state_s = ST_HALT;
                end else begin
                    state_s = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if ((opcode_s == OP_INPUT) && !Enter) begin
                    state_s = ST_EXECUTE;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_HALT:    state_s = ST_HALT;
            default:    state_s = ST_START;
        endcase
    end

    // Controller state, PC, IR and accumulator registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r <= ST_START;
            halt_r  <= 1'b0;
            pc_r    <= {ADDR_W{1'b0}};
            ir_r    <= {DATA_W{1'b0}};
            a_r     <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_s;
            halt_r  <= (state_s == ST_HALT);
            case (state_r)
                ST_FETCH: begin
                    ir_r <= mem_rdata_s;
                    pc_r <= pc_r + PC_STEP;
                end
                ST_EXECUTE: begin
                    // Jump tests use A as it stands entering EXECUTE.
                    case (opcode_s)
                        OP_LOAD:  a_r <= mem_rdata_s;
                        OP_ADD:   a_r <= a_r + mem_rdata_s;
                        OP_SUB:   a_r <= a_r - mem_rdata_s;
                        OP_INPUT: begin
                            if (Enter) begin
                                a_r <= Input;
                            end
                        end
                        OP_JZ: begin
                            if (aeq0_s) begin
                                pc_r <= ir_addr_s;
                            end
                        end
                        OP_JPOS: begin
                            if (apos_s) begin
                                pc_r <= ir_addr_s;
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Program RAM write port; contents deliberately survive Reset.
    always_ff @(posedge Clock) begin
        if (store_en_s) begin
            mem_r[ir_addr_s] <= a_r;
        end else if (prog_en_s) begin
            mem_r[ProgAddr] <= ProgData;
        end
    end

    assign Output = a_r;
    assign Halt   = halt_r;
    assign Aeq0   = aeq0_s;
    assign Apos   = apos_s;
    assign PC     = pc_r;
    assign IR     = ir_r;
    assign State  = state_r;

endmodule

// File: tb/tb_ep_core_param.sv
// Scoreboard bench for ep_core_param: an instruction-level interpreter predicts the
// halted machine state of each program; a monitor compares it when Halt rises.
module tb_ep_core_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8, ent8, pw8;
    logic [7:0] in8, pd8, out8, ir8;
    logic [4:0] pa8, pc8;
    logic       halt8, aeq8, apos8;
    logic [2:0] st8;

    logic        rst12, ent12, pw12;
    logic [11:0] in12, pd12, out12, ir12;
    logic [8:0]  pa12, pc12;
    logic        halt12, aeq12, apos12;
    logic [2:0]  st12;

    ep_core_param #(.DATA_W(8)) dut8 (
        .Clock(clk), .Reset(rst8), .Input(in8), .Enter(ent8), .ProgWr(pw8),
        .ProgAddr(pa8), .ProgData(pd8), .Output(out8), .Halt(halt8), .Aeq0(aeq8),
        .Apos(apos8), .PC(pc8), .IR(ir8), .State(st8));

    ep_core_param #(.DATA_W(12)) dut12 (
        .Clock(clk), .Reset(rst12), .Input(in12), .Enter(ent12), .ProgWr(pw12),
        .ProgAddr(pa12), .ProgData(pd12), .Output(out12), .Halt(halt12), .Aeq0(aeq12),
        .Apos(apos12), .PC(pc12), .IR(ir12), .State(st12));

    typedef struct {
        logic [7:0]   a;
        logic [4:0]   pc;
        logic [7:0]   ir;
        logic [255:0] mem;
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    exp_t       exp_q[$];
    logic [7:0] img[32];
    logic [7:0] ins[$];
    logic [7:0] in_q[$];
    int         done_cnt = 0;
    int         sub_cnt = 0;
    bit         force_stall = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] dut_mem();
        logic [255:0] v;
        for (int i = 0; i < 32; i++) v[i*8 +: 8] = dut8.mem_r[i];
        return v;
    endfunction

    function automatic logic [255:0] img_packed();
        logic [255:0] v;
        for (int i = 0; i < 32; i++) v[i*8 +: 8] = img[i];
        return v;
    endfunction

    // Reference: interpret the program instruction by instruction until HALT.
    task automatic model_push();
        logic [7:0] m[32];
        logic [7:0] a;
        logic [4:0] pc;
        logic [7:0] ir;
        logic [7:0] q[$];
        exp_t       e;
        int         steps;
        bit         halted;
        a = 8'd0; pc = 5'd0; ir = 8'd0; steps = 0; halted = 1'b0;
        for (int i = 0; i < 32; i++) m[i] = img[i];
        q = ins;
        while (!halted && steps < 1000) begin
            ir = m[pc];
            pc = pc + 5'd1;
            steps++;
            case (ir[7:5])
                3'd0: a = m[ir[4:0]];
                3'd1: m[ir[4:0]] = a;
                3'd2: a = a + m[ir[4:0]];
                3'd3: a = a - m[ir[4:0]];
                3'd4: a = (q.size() > 0) ? q.pop_front() : 8'd0;
                3'd5: if (a == 8'd0) pc = ir[4:0];
                3'd6: if (a != 8'd0 && a < 8'd128) pc = ir[4:0];
                default: halted = 1'b1;
            endcase
        end
        e.a = a; e.pc = pc; e.ir = ir;
        for (int i = 0; i < 32; i++) e.mem[i*8 +: 8] = m[i];
        exp_q.push_back(e);
    endtask

    task automatic clear_img();
        for (int i = 0; i < 32; i++) img[i] = 8'h00;
        ins.delete();
    endtask

    task automatic load8();
        rst8 = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            pw8 = 1'b1; pa8 = 5'(i); pd8 = img[i];
            @(negedge clk);
        end
        pw8 = 1'b0;
    endtask

    task automatic run8(input string name, input bit stall);
        int start;
        model_push();
        in_q = ins;
        force_stall = stall;
        start = done_cnt;
        rst8 = 1'b0;
        for (int c = 0; c < 2000 && done_cnt == start; c++) @(negedge clk);
        chk({name, "_halted"}, done_cnt - start, 1);
        if (done_cnt == start) exp_q.delete();
    endtask

    // Monitor: on each rising Halt pop the prediction and compare.
    initial begin
        exp_t e;
        bit   prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (halt8 && !prev) begin
                if (exp_q.size() == 0) begin
                    chk("sb_nonempty", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("acc", out8, e.a);
                    chk("pc", pc8, e.pc);
                    chk("ir", ir8, e.ir);
                    chk("state_halt", st8, 3'd7);
                    chk("aeq0", aeq8, (e.a == 8'd0));
                    chk("apos", apos8, (e.a != 8'd0 && e.a < 8'd128));
                    chk("ram", dut_mem(), e.mem);
                end
                done_cnt++;
            end
            prev = halt8;
        end
    end

    // Input driver: answers INPUT with a random (or forced 5-cycle) Enter stall.
    initial begin
        bit         in_input, expect_fetch;
        int         stall;
        logic [4:0] pc_hold;
        logic [7:0] last_in;
        in_input = 1'b0; expect_fetch = 1'b0; stall = 0; pc_hold = 5'd0; last_in = 8'd0;
        ent8 = 1'b0; in8 = 8'd0;
        forever begin
            @(negedge clk);
            if (expect_fetch) begin
                expect_fetch = 1'b0;
                chk("input_then_fetch", st8, 3'd1);
                chk("input_acc", out8, last_in);
            end
            if (rst8) begin
                in_input = 1'b0;
            end else if (!in_input && st8 == 3'd3 && ir8[7:5] == 3'd4) begin
                in_input = 1'b1;
                stall = force_stall ? 5 : $urandom_range(0, 2);
                pc_hold = pc8;
            end
            if (in_input) begin
                if (stall > 0) begin
                    ent8 = 1'b0;
                    if (force_stall) begin
                        chk("stall_state", st8, 3'd3);
                        chk("stall_pc", pc8, pc_hold);
                    end
                    stall--;
                end else begin
                    ent8 = 1'b1;
                    in8 = (in_q.size() > 0) ? in_q.pop_front() : 8'h00;
                    last_in = in8;
                    in_input = 1'b0;
                    expect_fetch = force_stall;
                end
            end else begin
                ent8 = 1'($urandom_range(0, 1));
                in8 = 8'($urandom);
            end
        end
    end

    // Counts executed SUB instructions since the last reset.
    initial begin
        forever begin
            @(negedge clk);
            if (rst8) sub_cnt = 0;
            else if (st8 == 3'd3 && ir8[7:5] == 3'd3) sub_cnt++;
        end
    end

    initial begin
        int  len, op, ad;
        bit  found, wrapped;
        logic [8:0] prev_pc;
        rst8 = 1'b1; pw8 = 1'b0; pa8 = 5'd0; pd8 = 8'd0;
        rst12 = 1'b1; pw12 = 1'b0; pa12 = 9'd0; pd12 = 12'd0; ent12 = 1'b0; in12 = 12'd0;
        repeat (3) @(negedge clk);
        chk("rst_state", st8, 3'd0);
        chk("rst_pc", pc8, 5'd0);
        chk("rst_ir", ir8, 8'd0);
        chk("rst_acc", out8, 8'd0);
        chk("rst_halt", halt8, 1'b0);
        chk("rst_aeq0", aeq8, 1'b1);

        // Two INPUTs, stores, then LOAD/SUB.
        clear_img();
        img[0] = 8'h80; img[1] = 8'h3E; img[2] = 8'h80; img[3] = 8'h3F;
        img[4] = 8'h1E; img[5] = 8'h7F; img[6] = 8'hE0;
        ins.push_back(8'd21); ins.push_back(8'd10);
        load8(); run8("prog_addsub", 1'b0);

        // Modular add, then two subtractions through zero.
        clear_img();
        img[20] = 8'd250; img[21] = 8'd10;
        img[0] = 8'h14; img[1] = 8'h55; img[2] = 8'hE0;
        load8(); run8("wrap_add", 1'b0);
        img[2] = 8'h75; img[3] = 8'h75; img[4] = 8'hE0;
        load8(); run8("wrap_sub", 1'b0);

        // INPUT held off by Enter for five cycles.
        clear_img();
        img[0] = 8'h80; img[1] = 8'hE0;
        ins.push_back(8'h55);
        load8(); run8("input_stall", 1'b1);

        // Countdown loop from 3.
        clear_img();
        img[30] = 8'd3; img[31] = 8'd1;
        img[0] = 8'h1E; img[1] = 8'h7F; img[2] = 8'hA4; img[3] = 8'hC1; img[4] = 8'hE0;
        load8(); run8("countdown", 1'b0);
        chk("countdown_passes", sub_cnt, 3);

        // Reset during a STORE's EXECUTE cycle.
        clear_img();
        img[20] = 8'h5A; img[25] = 8'h11;
        for (int i = 21; i < 32; i++) if (i != 25) img[i] = 8'($urandom);
        img[0] = 8'h14; img[1] = 8'h39; img[2] = 8'hE0;
        load8();
        rst8 = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            found = (st8 == 3'd3 && ir8 == 8'h39);
        end
        chk("reach_store_exec", found, 1'b1);
        rst8 = 1'b1;
        @(negedge clk);
        chk("rst_store_blocked", dut8.mem_r[25], 8'h11);
        chk("rst_mid_acc", out8, 8'd0);
        chk("rst_mid_pc", pc8, 5'd0);
        chk("rst_mid_ir", ir8, 8'd0);
        chk("rst_mid_state", st8, 3'd0);
        chk("rst_mid_ram", dut_mem(), img_packed());
        run8("rerun", 1'b0);

        // Random straight-line programs with forward-only jumps.
        for (int t = 0; t < 20; t++) begin
            clear_img();
            len = $urandom_range(4, 14);
            for (int i = 0; i < len - 1; i++) begin
                op = $urandom_range(0, 6);
                if (op == 5 || op == 6) ad = $urandom_range(i + 1, len - 1);
                else ad = $urandom_range(20, 31);
                if (op == 4) ins.push_back(8'($urandom));
                img[i] = {3'(op), 5'(ad)};
            end
            img[len-1] = 8'hE0;
            for (int d = 20; d < 32; d++) img[d] = 8'($urandom);
            load8(); run8("random", 1'b0);
        end

        // 12-bit core: PC wraps past 511; ProgWr ignored while running.
        for (int i = 0; i < 512; i++) begin
            pw12 = 1'b1; pa12 = 9'(i);
            pd12 = (i == 0) ? 12'hA02 : ((i == 1) ? 12'hE00 : 12'h003);
            @(negedge clk);
        end
        pw12 = 1'b0;
        rst12 = 1'b0;
        @(negedge clk);
        chk("w12_start_state", st12, 3'd1);
        chk("w12_start_pc", pc12, 9'd0);
        @(negedge clk);
        chk("w12_fetch_state", st12, 3'd2);
        chk("w12_fetch_pc", pc12, 9'd1);
        chk("w12_fetch_ir", ir12, 12'hA02);
        wrapped = 1'b0;
        prev_pc = pc12;
        for (int c = 0; c < 3000 && !halt12; c++) begin
            @(negedge clk);
            if (prev_pc == 9'd511 && pc12 == 9'd0) wrapped = 1'b1;
            prev_pc = pc12;
            if (c == 400 || c == 900) begin
                pw12 = 1'b1; pa12 = 9'd100; pd12 = 12'hABC;
            end else begin
                pw12 = 1'b0;
            end
        end
        pw12 = 1'b0;
        chk("w12_halted", halt12, 1'b1);
        chk("w12_pc_wrapped", wrapped, 1'b1);
        chk("w12_pc", pc12, 9'd2);
        chk("w12_acc", out12, 12'd3);
        chk("w12_prog_ignored", dut12.mem_r[100], 12'h003);
        pw12 = 1'b1; pa12 = 9'd100; pd12 = 12'hABC;
        @(negedge clk);
        pw12 = 1'b0;
        @(negedge clk);
        chk("w12_prog_in_halt", dut12.mem_r[100], 12'hABC);
        chk("w12_acc_frozen", out12, 12'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
